// File: rtl/gb_dma_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gb_dma_pkg
// Description : Shared constants, state encoding and source-page remap for
//               the Gameboy OAM DMA controller.
//               Optional feature macro: OAM_DMA_ECHO_MIRROR_EN
// Revision    : 1.0 - initial release
// ============================================================================
package gb_dma_pkg;

  localparam int          OAM_DMA_BYTES = 160;
  localparam logic [7:0]  OAM_DMA_LAST  = 8'(OAM_DMA_BYTES - 1);
  localparam logic [15:0] FF46_ADDR     = 16'hFF46;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } oam_dma_state_t;

  // Map the FF46 page to the page actually driven on the source bus.
  // With the echo mirror enabled, E0..FF fold down onto C0..DF, the same
  // way the echo-RAM decoder aliases them.
  function automatic logic [7:0] oam_dma_src_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
    return page;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma
// Description : OAM DMA controller. A CPU write to FF46 copies 160 bytes
//               from page {FF46, 8'h00} into OAM, one byte per M-cycle.
//               Optional feature macro: OAM_DMA_ECHO_MIRROR_EN (E0..FF pages
//               are read from their C0..DF echo source).
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma
  import gb_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        cpu_sel,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  output logic        dma_active,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_di
);

  oam_dma_state_t state;
  oam_dma_state_t state_next;
  logic [7:0]     count;
  logic [7:0]     page;
  logic           accept;
  logic           write_byte;
  logic           last_byte;

  // An FF46 write wins over everything else on its edge, including a
  // byte that would otherwise be written in XFER.
  assign accept     = ce & cpu_sel & cpu_wr;
  assign write_byte = ce & ~accept & (state == XFER);
  assign last_byte  = (count == OAM_DMA_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: restart on FF46 write, otherwise advance per M-cycle.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = START;
    end else if (ce) begin
      case (state)
        START:   state_next = XFER;
        XFER:    state_next = last_byte ? IDLE : XFER;
        default: state_next = state;
      endcase
    end
  end

  // Output decode: busy flags and source address from current state.
  always_comb begin
    dma_active = (state != IDLE);
    dma_rd     = (state == XFER);
    dma_addr   = {oam_dma_src_page(page), count};
    cpu_do     = page;
  end

  // FF46 page register; holds the unmapped value for readback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      page <= 8'h00;
    end else if (accept) begin
      page <= cpu_di;
    end
  end

  // Byte counter: cleared on a new transfer, wraps to 0 after the last byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'h00;
    end else if (accept) begin
      count <= 8'h00;
    end else if (write_byte) begin
      count <= last_byte ? 8'h00 : (count + 8'h01);
    end
  end

  // OAM write port: capture the source byte and pulse oam_wr for one clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oam_wr   <= 1'b0;
      oam_addr <= 8'h00;
      oam_di   <= 8'h00;
    end else begin
      oam_wr <= write_byte;
      if (write_byte) begin
        oam_addr <= count;
        oam_di   <= dma_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma
// Description : Directed self-checking bench for oam_dma.
//               Honours OAM_DMA_ECHO_MIRROR_EN for the echo-page expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [1:0]  phase = 2'd0;
  logic        cpu_sel = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_di = 8'h00;
  logic [7:0]  cpu_do;
  logic        dma_active;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        oam_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_di;

  logic        sprite_mode = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          wr_n, rd_n, busy, wide_err;
  logic        prev_wr = 1'b0;
  logic [7:0]  wr_addr [0:511];
  logic [7:0]  wr_di   [0:511];
  logic [15:0] rd_addr [0:511];
  logic [7:0]  oam_mem [0:255];

  oam_dma dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .cpu_sel    (cpu_sel),
    .cpu_wr     (cpu_wr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .dma_active (dma_active),
    .dma_rd     (dma_rd),
    .dma_addr   (dma_addr),
    .dma_data   (dma_data),
    .oam_wr     (oam_wr),
    .oam_addr   (oam_addr),
    .oam_di     (oam_di)
  );

  always #5 clk = ~clk;

  // M-cycle enable: high one clk in four, changing just after posedge.
  always @(posedge clk) begin
    phase <= phase + 2'd1;
    ce    <= (phase == 2'd2);
  end

  // Source memory: page C1 holds its low address byte, other pages the low
  // byte xor A5; sprite mode overlays sprite 0 at C100..C103.
  always_comb begin
    dma_data = dma_addr[7:0] ^ ((dma_addr[15:8] == 8'hC1) ? 8'h00 : 8'hA5);
    if (sprite_mode && dma_addr[15:8] == 8'hC1) begin
      case (dma_addr[7:0])
        8'h00:   dma_data = 8'h50;
        8'h01:   dma_data = 8'h20;
        8'h02:   dma_data = 8'h07;
        8'h03:   dma_data = 8'h80;
        default: dma_data = dma_addr[7:0];
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    if (oam_wr) begin
      if (prev_wr) wide_err++;
      if (wr_n < 512) begin
        wr_addr[wr_n] = oam_addr;
        wr_di[wr_n]   = oam_di;
      end
      wr_n++;
      oam_mem[oam_addr] = oam_di;
    end
    if (ce && dma_active) busy++;
    if (ce && dma_rd) begin
      if (rd_n < 512) rd_addr[rd_n] = dma_addr;
      rd_n++;
    end
    prev_wr = oam_wr;
  endtask

  task automatic clear_log();
    wr_n = 0; rd_n = 0; busy = 0; wide_err = 0;
  endtask

  task automatic cpu_write(input logic [7:0] v);
    step();
    while (!ce) step();
    cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_di = v;
    @(posedge clk);
    #1;
    cpu_sel = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic wait_ce(input int n);
    repeat (n) begin
      step();
      while (!ce) step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic capture(input string name);
    int k = 0;
    do begin
      step();
      k++;
    end while (dma_active && k < 2000);
    if (dma_active) begin
      total++; bad++;
      $display("FAIL %s timeout: dma_active still high after %0d clks", name, k);
    end
  endtask

  task automatic test_reset();
    int g;
    total++;
    if ({cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_di} !== 50'd0) begin
      bad++; $display("FAIL reset_state got %h want 0",
        {cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_di});
    end
    @(negedge clk); reset_n = 1'b1;
    // Write to another address: must be ignored.
    step(); while (!ce) step();
    cpu_sel = 1'b0; cpu_wr = 1'b1; cpu_di = 8'h77;
    @(posedge clk); #1; cpu_wr = 1'b0;
    repeat (8) step();
    total++;
    if ({dma_active, cpu_do} !== 9'd0) begin
      bad++; $display("FAIL other_addr got active=%b cpu_do=%h want 0/00", dma_active, cpu_do);
    end
    // Reset in the middle of a transfer at count 40.
    clear_log();
    cpu_write(8'hC1);
    g = 0;
    while (wr_n < 40 && g < 2000) begin step(); g++; end
    total++;
    if (wr_n !== 40) begin bad++; $display("FAIL mid_reset_setup got wr_n=%0d want 40", wr_n); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_di} !== 50'd0) begin
      bad++; $display("FAIL mid_reset_async got %h want 0",
        {cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_di});
    end
    @(posedge clk); #1;
    total++;
    if ({cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_di} !== 50'd0) begin
      bad++; $display("FAIL mid_reset_clk got %h want 0",
        {cpu_do, dma_active, dma_rd, dma_addr, oam_wr, oam_addr, oam_di});
    end
    @(negedge clk); reset_n = 1'b1;
    clear_log();
    repeat (20) step();
    total++;
    if (dma_active !== 1'b0 || wr_n !== 0) begin
      bad++; $display("FAIL post_reset_idle got active=%b writes=%0d want 0/0", dma_active, wr_n);
    end
  endtask

  task automatic test_transfer();
    int e;
    clear_log();
    cpu_write(8'hC1);
    capture("transfer");
    total++;
    if (cpu_do !== 8'hC1) begin bad++; $display("FAIL xfer_cpu_do got %h want c1", cpu_do); end
    total++;
    if (wr_n !== 160) begin bad++; $display("FAIL xfer_wr_count got %0d want 160", wr_n); end
    e = -1;
    for (int i = 0; i < 160; i++)
      if (e < 0 && (wr_addr[i] !== 8'(i) || wr_di[i] !== 8'(i))) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL xfer_wr_seq at %0d got addr=%h di=%h want %h/%h",
        e, wr_addr[e], wr_di[e], 8'(e), 8'(e));
    end
    total++;
    if (rd_n !== 160) begin bad++; $display("FAIL xfer_rd_count got %0d want 160", rd_n); end
    e = -1;
    for (int i = 0; i < 160; i++)
      if (e < 0 && rd_addr[i] !== (16'hC100 + 16'(i))) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL xfer_rd_seq at %0d got %h want %h", e, rd_addr[e], 16'hC100 + 16'(e));
    end
    total++;
    if (busy + 1 !== 162) begin bad++; $display("FAIL xfer_busy got %0d want 162", busy + 1); end
    total++;
    if (wide_err !== 0) begin bad++; $display("FAIL xfer_pulse_width got %0d wide pulses want 0", wide_err); end
    total++;
    if (dma_rd !== 1'b0) begin bad++; $display("FAIL xfer_rd_end got %b want 0", dma_rd); end
  endtask

  task automatic test_sprite();
    logic [7:0] exp [0:3];
    exp[0] = 8'h50; exp[1] = 8'h20; exp[2] = 8'h07; exp[3] = 8'h80;
    sprite_mode = 1'b1;
    clear_log();
    cpu_write(8'hC1);
    capture("sprite");
    sprite_mode = 1'b0;
    for (int f = 0; f < 4; f++) begin
      total++;
      if (oam_mem[f] !== exp[f]) begin
        bad++; $display("FAIL sprite0_field%0d got %h want %h", f, oam_mem[f], exp[f]);
      end
    end
  endtask

  task automatic test_restart();
    int e;
    clear_log();
    cpu_write(8'hC1);
    wait_ce(49);
    cpu_write(8'hD0);
    total++;
    if (oam_wr !== 1'b0 || dma_active !== 1'b1 || cpu_do !== 8'hD0) begin
      bad++; $display("FAIL restart_edge got wr=%b active=%b cpu_do=%h want 0/1/d0",
        oam_wr, dma_active, cpu_do);
    end
    total++;
    if (wr_n !== 48 || wr_addr[47] !== 8'd47) begin
      bad++; $display("FAIL restart_old_writes got n=%0d last=%h want 48/2f", wr_n, wr_addr[47]);
    end
    clear_log();
    capture("restart");
    total++;
    if (wr_n !== 160) begin bad++; $display("FAIL restart_wr_count got %0d want 160", wr_n); end
    e = -1;
    for (int i = 0; i < 160; i++)
      if (e < 0 && (wr_addr[i] !== 8'(i) || wr_di[i] !== (8'(i) ^ 8'hA5) ||
                    rd_addr[i] !== (16'hD000 + 16'(i)))) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL restart_seq at %0d got addr=%h di=%h src=%h want %h/%h/%h",
        e, wr_addr[e], wr_di[e], rd_addr[e], 8'(e), 8'(e) ^ 8'hA5, 16'hD000 + 16'(e));
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    cpu_write(8'hC1);
    wait_ce(160);
    cpu_write(8'hD0);
    total++;
    if (wr_n !== 159 || oam_wr !== 1'b0 || dma_active !== 1'b1) begin
      bad++; $display("FAIL b2b_edge got writes=%0d wr=%b active=%b want 159/0/1",
        wr_n, oam_wr, dma_active);
    end
    wait_ce(1);
    total++;
    if (dma_rd !== 1'b1 || dma_addr !== 16'hD000) begin
      bad++; $display("FAIL b2b_xfer_start got rd=%b addr=%h want 1/d000", dma_rd, dma_addr);
    end
    clear_log();
    capture("b2b");
    total++;
    if (wr_n !== 160 || wr_addr[159] !== 8'd159) begin
      bad++; $display("FAIL b2b_second got n=%0d last=%h want 160/9f", wr_n, wr_addr[159]);
    end
  endtask

  task automatic test_echo();
    logic [7:0] pg;
`ifdef OAM_DMA_ECHO_MIRROR_EN
    pg = 8'hDE;
`else
    pg = 8'hFE;
`endif
    clear_log();
    cpu_write(8'hFE);
    capture("echo");
    total++;
    if (rd_n !== 160 || rd_addr[0] !== {pg, 8'h00} || rd_addr[159] !== {pg, 8'h9F}) begin
      bad++; $display("FAIL echo_src got n=%0d first=%h last=%h want 160/%h/%h",
        rd_n, rd_addr[0], rd_addr[159], {pg, 8'h00}, {pg, 8'h9F});
    end
    total++;
    if (cpu_do !== 8'hFE) begin bad++; $display("FAIL echo_cpu_do got %h want fe", cpu_do); end
  endtask

  initial begin
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_transfer();
    test_sprite();
    test_restart();
    test_back_to_back();
    test_echo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
